lzd_norm_pipe: RTL and testbench
================================

// Module: lzd_norm_pipe
// PURPOSE
//  Pipelined, parametrised successor to the combinational leading-zero detector in the FPHUB adder path.
//  Per transaction it forms |A-B| (or passes A), counts leading zeros, and emits the left-normalised magnitude.
//  It also emits the swap (A<B) and zero flags.
//  Sits between the mantissa-align stage and the exponent-adjust stage; valid/ready on both sides.
// PARAMETERS
//  M                   23  mantissa width (explicit bits)
//  EXTRA_BITS_MANTISSA  7  extra guard/HUB bits appended to mantissa
//  SIGN_MANTISSA_BIT    1  sign bit stripped before detection
//  W          M+EXTRA_BITS_MANTISSA-SIGN_MANTISSA_BIT  datapath width (default 29)
//  SHIFT_W    $clog2(W)    count field width (default 5); count port is SHIFT_W+1 bits
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          input transaction valid
//  in_ready   out  1          block accepts input this cycle
//  in_mode    in   1          0: operate on |A-B|; 1: operate on A directly (B ignored)
//  in_a       in   W          operand A (unsigned magnitude)
//  in_b       in   W          operand B (unsigned magnitude)
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream accepts result
//  out_lzc    out  SHIFT_W+1  leading-zero count; {1'b1,{SHIFT_W{1'b0}}} when operand is zero
//  out_norm   out  W          operand << lzc (MSB set unless zero); 0 when zero
//  out_a_lt_b out  1          1 iff mode 0 and A<B (operands were swapped)
//  out_zero   out  1          1 iff operand value is 0
// BEHAVIOUR
//  - Reset (async assert, sync deassert by integrator): both stage valids=0, out_valid=0,
//    all out_* data=0; in_ready=1 in the first cycle after reset.
//  - Stage 1 registers: d = mode ? A : (A>=B ? A-B : B-A); a_lt_b = !mode && (A<B).
//  - Stage 2 registers: lzc, norm, zero, a_lt_b computed from stage-1 d.
//  - Latency: 2 cycles from in_valid&in_ready to out_valid when out_ready is held high.
//  - Throughput: 1 transaction/cycle when out_ready is held high.
//  - Handshake: transfer occurs only on valid&&ready.
//  - A stage loads when it is empty or its contents are being consumed this cycle.
//  - in_ready = !s1_valid || s1_moves (combinational; no dependency on in_valid).
//  - Under backpressure (out_ready=0): out_* are held stable while out_valid=1; up to 2 transactions are buffered.
//    in_ready drops only when both stages are full.
//  - Simultaneous accept and emit in the same cycle is legal; no bubble is inserted.
//  - lzc = (W-1) - index of highest set bit. Zero operand: lzc = 1<<SHIFT_W (e.g. 32), zero=1, norm=0.
//  - Width rule: subtraction is W-bit unsigned with no wrap, because the larger operand is always the minuend.
//  - A<B and mode=1 together: a_lt_b=0.
//  - Reset mid-operation: in-flight transactions are discarded; nothing is emitted after reset release.
//  - No $display or other simulation side effects in synthesised code.
// STRUCTURE
//  - lzd_pkg: localparam width helpers; typedef struct lzd_result_t {lzc, norm, a_lt_b, zero};
//    typedef logic [W-1:0] mant_t; constant LZC_ZERO.
//  - Sub-module lzc_tree: combinational, parametrised leading-zero counter.
//    Implemented as a log-depth tree that pads to a power of 2; outputs {valid, count}.
//    Instantiated in stage 2 and reusable elsewhere in the adder.
//  - The normaliser is a barrel shift in stage 2; a separate module is not required.
// TESTING (W=29, SHIFT_W=5, mode 0 unless stated)
//  1 A=0x0000100, B=0x0000080, out_ready=1 -> 2 cycles later: lzc=21, norm=0x10000000, a_lt_b=0, zero=0.
//  2 A=0x0000080, B=0x0000100 -> lzc=21, norm=0x10000000, a_lt_b=1.
//  3 A=B=0x0ABCDEF -> lzc=6'b100000 (32), norm=0, zero=1. Then mode=1, A=0x1 -> lzc=28, norm=0x10000000.
//  4 Back-to-back stream of 8 transactions with out_ready=1:
//    - out_valid high for 8 consecutive cycles, in order, no bubbles.
//    - out_ready=0 for 5 cycles mid-stream: in_ready falls after 2 accepts, outputs stable, no loss/duplication.
//  5 rst_n asserted with 2 transactions in flight -> out_valid=0 and outputs 0 immediately.
//    After release: no stale outputs, in_ready=1.
//  6 Random operands vs reference model (clz of |A-B|) for 10k transactions with random in_valid/out_ready.
//    Scoreboard requires exact match.

Source files
------------

// File: rtl/lzd_pkg.sv
// Shared widths, types and helpers for the leading-zero/normalise pipeline.
package lzd_pkg;

  localparam int unsigned M                   = 23;
  localparam int unsigned EXTRA_BITS_MANTISSA = 7;
  localparam int unsigned SIGN_MANTISSA_BIT   = 1;
  localparam int unsigned W                   = M + EXTRA_BITS_MANTISSA - SIGN_MANTISSA_BIT;
  localparam int unsigned SHIFT_W             = $clog2(W);
  localparam int unsigned LZC_W               = SHIFT_W + 1;

  typedef logic [W-1:0]     mant_t;
  typedef logic [LZC_W-1:0] lzc_t;

  // Count reported for an all-zero operand: one past any real count.
  localparam lzc_t LZC_ZERO = {1'b1, {SHIFT_W{1'b0}}};

  typedef struct packed {
    lzc_t  lzc;
    mant_t norm;
    logic  a_lt_b;
    logic  zero;
  } lzd_result_t;

  // Magnitude of the difference; the larger operand is always the minuend.
  function automatic mant_t abs_diff(input mant_t a, input mant_t b);
    return (a >= b) ? mant_t'(a - b) : mant_t'(b - a);
  endfunction

endpackage

// File: rtl/lzc_tree.sv
// Combinational leading-zero counter built as a log-depth pairwise tree.
// Input is padded on the LSB side to a power of two, which leaves the count unchanged.
module lzc_tree #(
  parameter int unsigned WIDTH = 29
) (
  input  logic [WIDTH-1:0]         data,
  output logic                     valid_c,
  output logic [$clog2(WIDTH)-1:0] count_c
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 1 << CW;

  logic [PW-1:0] padded;

  assign padded = PW'(data) << (PW - WIDTH);

  // Reduce adjacent node pairs level by level; the high-order node wins when it has a one.
  always_comb begin : tree
    logic [PW-1:0] v;
    logic [CW-1:0] c [PW];
    v = padded;
    for (int i = 0; i < int'(PW); i++) begin
      c[i] = '0;
    end
    for (int l = 1; l <= int'(CW); l++) begin
      for (int n = 0; n < int'(PW >> l); n++) begin
        if (v[2*n+1]) begin
          c[n] = c[2*n+1];
        end else begin
          c[n] = c[2*n] | (CW'(1) << (l - 1));
        end
        v[n] = v[2*n+1] | v[2*n];
      end
    end
    valid_c = v[0];
    count_c = c[0];
  end

endmodule

// File: rtl/lzd_norm_pipe.sv
// Two-stage |A-B| / leading-zero / normalise pipeline with valid/ready on both sides.
// Stage 1 holds the magnitude, stage 2 holds the count, shifted magnitude and flags.
module lzd_norm_pipe
  import lzd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LZC_W-1:0] out_lzc,
  output logic [W-1:0]     out_norm,
  output logic             out_a_lt_b,
  output logic             out_zero
);

  logic               s1_valid;
  mant_t              s1_d;
  logic               s1_a_lt_b;
  logic               s2_valid;
  lzd_result_t        s2_res;

  logic               s2_load;
  logic               s1_moves;
  mant_t              s1_d_next;
  logic               s1_lt_next;
  logic               tree_valid;
  logic [SHIFT_W-1:0] tree_count;
  lzd_result_t        s2_next;

  // A stage loads when empty or when its contents leave this cycle.
  assign s2_load  = !s2_valid || out_ready;
  assign s1_moves = s1_valid && s2_load;
  assign in_ready = !s1_valid || s1_moves;

  // Operand selection and magnitude for stage 1.
  always_comb begin
    s1_lt_next = !in_mode && (in_a < in_b);
    s1_d_next  = in_mode ? in_a : abs_diff(in_a, in_b);
  end

  // Stage 1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_d      <= '0;
      s1_a_lt_b <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_d      <= s1_d_next;
        s1_a_lt_b <= s1_lt_next;
      end
    end
  end

  lzc_tree #(
    .WIDTH (W)
  ) u_lzc_tree (
    .data    (s1_d),
    .valid_c (tree_valid),
    .count_c (tree_count)
  );

  // Count, barrel-shift normalise and flags for stage 2.
  always_comb begin
    s2_next        = '0;
    s2_next.zero   = !tree_valid;
    s2_next.lzc    = tree_valid ? LZC_W'(tree_count) : LZC_ZERO;
    s2_next.norm   = s1_d << tree_count;
    s2_next.a_lt_b = s1_a_lt_b;
  end

  // Stage 2 register; drives the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_res <= s2_next;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_lzc    = s2_res.lzc;
  assign out_norm   = s2_res.norm;
  assign out_a_lt_b = s2_res.a_lt_b;
  assign out_zero   = s2_res.zero;

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// Bench for lzd_norm_pipe: directed vector table, stream/backpressure/reset sequences,
// and a randomized run scored against an arithmetic reference model.
module tb_lzd_norm_pipe;

  localparam int TW = 29;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [TW-1:0] in_a;
  logic [TW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [5:0]    out_lzc;
  logic [TW-1:0] out_norm;
  logic          out_a_lt_b;
  logic          out_zero;

  lzd_norm_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mode    (in_mode),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_lzc    (out_lzc),
    .out_norm   (out_norm),
    .out_a_lt_b (out_a_lt_b),
    .out_zero   (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: magnitude via plain arithmetic, count via position of highest set bit.
  function automatic logic [36:0] ref_model(input bit mode, input logic [TW-1:0] a, input logic [TW-1:0] b);
    longint unsigned d;
    int msb;
    logic [5:0] lzc;
    logic [TW-1:0] norm;
    bit lt;
    bit zero;
    lt = !mode && (a < b);
    if (mode) d = longint'(a);
    else if (a >= b) d = longint'(a) - longint'(b);
    else d = longint'(b) - longint'(a);
    msb = -1;
    for (int k = 0; k < TW; k++) if (d >= (64'd1 << k)) msb = k;
    if (msb < 0) begin
      lzc = 6'd32; norm = '0; zero = 1'b1;
    end else begin
      lzc = 6'(TW - 1 - msb); norm = TW'(d << (TW - 1 - msb)); zero = 1'b0;
    end
    return {lzc, norm, lt, zero};
  endfunction

  // Scoreboard: expectations pushed on input transfers, popped on output transfers.
  logic [36:0] exp_q[$];
  logic [36:0] exp_item;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(ref_model(in_mode, in_a, in_b));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", 64'd1, 64'd0);
        end else begin
          exp_item = exp_q.pop_front();
          check("sb_result", {out_lzc, out_norm, out_a_lt_b, out_zero}, exp_item);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit            mode;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic [5:0]    lzc;
    logic [TW-1:0] norm;
    bit            lt;
    bit            zero;
  } vec_t;

  vec_t vecs[11];

  task automatic rand_ops();
    int kind;
    kind   = $urandom_range(0, 3);
    in_a   = TW'($urandom) >> $urandom_range(0, TW - 1);
    case (kind)
      0:       in_b = TW'($urandom) >> $urandom_range(0, TW - 1);
      1:       in_b = in_a;
      2:       in_b = in_a ^ (TW'(1) << $urandom_range(0, TW - 1));
      default: in_b = in_a + TW'($urandom_range(0, 3));
    endcase
    in_mode = ($urandom_range(0, 3) == 0);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  int            lat;
  logic [11:0]   ov;
  int            n_acc;
  bit            acc;
  bit            have_cap;
  logic [36:0]   cap;
  int            sent;
  int            n_rand;
  int            cyc;

  initial begin
    vecs[0]  = '{1'b0, 29'h0000100, 29'h0000080,  6'd21, 29'h10000000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 29'h0000080, 29'h0000100,  6'd21, 29'h10000000, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 29'h0ABCDEF, 29'h0ABCDEF,  6'd32, 29'h00000000, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 29'h0000001, 29'h1FFFFFFF, 6'd28, 29'h10000000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 29'h1FFFFFFF, 29'h0000000, 6'd0,  29'h1FFFFFFF, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 29'h0000000, 29'h1FFFFFFF, 6'd0,  29'h1FFFFFFF, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 29'h0000000, 29'h0000123,  6'd32, 29'h00000000, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 29'h0000003, 29'h0000002,  6'd28, 29'h10000000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 29'h0FFFFFFF, 29'h0000000, 6'd1,  29'h1FFFFFFE, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 29'h10000000, 29'h0FFFFFFF, 6'd28, 29'h10000000, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 29'h0012345, 29'h0000000,  6'd12, 29'h12345000, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;

    // Reset state.
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_lzc", 64'(out_lzc), 64'd0);
    check("rst_out_norm", 64'(out_norm), 64'd0);
    check("rst_out_flags", 64'({out_a_lt_b, out_zero}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors: latency of two cycles and exact fields.
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_mode = vecs[i].mode; in_a = vecs[i].a; in_b = vecs[i].b; out_ready = 1'b1;
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      check($sformatf("vec%0d_lzc", i), 64'(out_lzc), 64'(vecs[i].lzc));
      check($sformatf("vec%0d_norm", i), 64'(out_norm), 64'(vecs[i].norm));
      check($sformatf("vec%0d_a_lt_b", i), 64'(out_a_lt_b), 64'(vecs[i].lt));
      check($sformatf("vec%0d_zero", i), 64'(out_zero), 64'(vecs[i].zero));
      @(posedge clk); #1;
    end
    drain("vec_drain");

    // Back-to-back stream of 8: out_valid high for 8 consecutive cycles.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ov[i] = out_valid;
      if (i < 8) begin
        in_valid = 1'b1;
        rand_ops();
        check("stream_in_ready", 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("stream_out_valid_pattern", 64'(ov), 64'h3FC);
    drain("stream_drain");

    // Backpressure: 5 stalled cycles, two accepts then in_ready low, outputs held.
    out_ready = 1'b0; in_valid = 1'b1; rand_ops();
    n_acc = 0; have_cap = 1'b0;
    for (int c = 0; c < 5; c++) begin
      acc = in_ready;
      if (acc) n_acc++;
      if (out_valid) begin
        if (!have_cap) begin
          cap = {out_lzc, out_norm, out_a_lt_b, out_zero};
          have_cap = 1'b1;
        end else begin
          check("bp_output_stable", {out_lzc, out_norm, out_a_lt_b, out_zero}, cap);
        end
      end
      @(posedge clk); #1;
      if (acc) rand_ops();
    end
    check("bp_accepts", 64'(n_acc), 64'd2);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid_held", 64'(out_valid), 64'd1);
    check("bp_output_stable_end", {out_lzc, out_norm, out_a_lt_b, out_zero}, cap);
    out_ready = 1'b1;
    sent = 0; cyc = 0;
    while (sent < 4 && cyc < 40) begin
      acc = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin sent++; rand_ops(); end
    end
    in_valid = 1'b0;
    check("bp_resume_sent", 64'(sent), 64'd4);
    drain("bp_drain");

    // Reset with two transactions in flight.
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b0; in_a = 29'h100; in_b = 29'h80;
    @(posedge clk); #1;
    in_a = 29'h5; in_b = 29'h1FFFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rstmid_pre_valid", 64'(out_valid), 64'd1);
    check("rstmid_pre_lzc", 64'(out_lzc), 64'd21);
    rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", 64'(out_valid), 64'd0);
    check("rstmid_out_lzc", 64'(out_lzc), 64'd0);
    check("rstmid_out_norm", 64'(out_norm), 64'd0);
    check("rstmid_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    check("rstmid_release_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rstmid_no_stale", 64'(out_valid), 64'd0);
    end

    // Randomized traffic against the reference model.
    n_rand = 0; cyc = 0; acc = 1'b0; in_valid = 1'b0;
    while (n_rand < 10000 && cyc < 60000) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        rand_ops();
      end
      acc = in_valid && in_ready;
      if (acc) n_rand++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("rand_count", 64'(n_rand), 64'd10000);
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
